// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU/branch definitions: op encodings, resolver
//                states and op classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Size of one uncompressed instruction; fall-through PC step.
    localparam int INSN_BYTES = 4;

    // Decoded operation encodings, shared with the comparator.
    typedef enum logic [3:0] {
        OP_BEQ  = 4'd0,
        OP_BNE  = 4'd1,
        OP_BLT  = 4'd2,
        OP_BGE  = 4'd3,
        OP_BLTU = 4'd4,
        OP_BGEU = 4'd5,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10
    } op_e;

    // Resolver control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } res_state_e;

    // Conditional branch ops occupy the contiguous range BEQ..BGEU.
    function automatic logic is_branch(input logic [3:0] op);
        return (op <= OP_BGEU);
    endfunction

    // Set-less-than ops produce a writeback word instead of a branch.
    function automatic logic is_set(input logic [3:0] op);
        return (op == OP_SLT) || (op == OP_SLTU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Increment on request unless already saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolver
//  Description : Turns the registered comparator flag into a branch decision
//                for fetch (valid/ready) or an SLT/SLTU writeback pulse.
//                One operation in flight; flush and reset cancel it.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4,
    parameter int CNT_W  = 16
) (
    input  logic             soc_clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [XLEN-1:0]  req_pc,
    input  logic [XLEN-1:0]  req_imm,
    input  logic             cmp_con_met,
    input  logic             flush,
    output logic             br_valid,
    input  logic             br_ready,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic             br_misaligned,
    output logic             wb_valid,
    output logic [XLEN-1:0]  wb_data,
    output logic             op_illegal,
    output logic [CNT_W-1:0] stat_resolved,
    output logic [CNT_W-1:0] stat_taken
);

    import alu_pkg::*;

    localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] c_INSN_STEP  = XLEN'(INSN_BYTES);

    res_state_e        r_state;
    op_e               r_op;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic              r_br_valid;
    logic              r_br_taken;
    logic [XLEN-1:0]   r_br_target;
    logic              r_br_mis;
    logic              r_wb_valid;
    logic              r_wb_flag;
    logic              r_illegal;

    logic [XLEN-1:0]   w_taken_target;
    logic              w_taken_mis;
    logic              w_handshake;
    logic              w_taken_inc;

    // Taken target wraps modulo 2^XLEN; alignment only matters when taken.
    assign w_taken_target = r_pc + r_imm;
    assign w_taken_mis    = |(w_taken_target & c_ALIGN_MASK);

    // Flush wins over a simultaneous fetch handshake.
    assign w_handshake = r_br_valid && br_ready && !flush;
    assign w_taken_inc = w_handshake && r_br_taken;

    // Resolver FSM with all result outputs registered.
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= OP_BEQ;
            r_pc        <= '0;
            r_imm       <= '0;
            r_br_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_br_mis    <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_flag   <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_br_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_br_mis    <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_flag   <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_flag  <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (is_branch(req_op) || is_set(req_op)) begin
                            r_op    <= op_e'(req_op);
                            r_pc    <= req_pc;
                            r_imm   <= req_imm;
                            r_state <= WAIT;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (is_branch(r_op)) begin
                        r_br_valid  <= 1'b1;
                        r_br_taken  <= cmp_con_met;
                        r_br_target <= cmp_con_met ? w_taken_target : (r_pc + c_INSN_STEP);
                        r_br_mis    <= cmp_con_met && w_taken_mis;
                        r_state     <= OUT;
                    end else begin
                        r_wb_valid <= 1'b1;
                        r_wb_flag  <= cmp_con_met;
                        r_state    <= IDLE;
                    end
                end
                OUT: begin
                    if (br_ready) begin
                        r_br_valid  <= 1'b0;
                        r_br_taken  <= 1'b0;
                        r_br_target <= '0;
                        r_br_mis    <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign br_valid      = r_br_valid;
    assign br_taken      = r_br_taken;
    assign br_target     = r_br_target;
    assign br_misaligned = r_br_mis;
    assign wb_valid      = r_wb_valid;
    assign wb_data       = {{(XLEN-1){1'b0}}, r_wb_flag};
    assign op_illegal    = r_illegal;

    sat_counter #(.WIDTH(CNT_W)) u_stat_resolved (
        .clk     (soc_clk),
        .rst     (reset),
        .i_inc   (w_handshake),
        .o_count (stat_resolved)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stat_taken (
        .clk     (soc_clk),
        .rst     (reset),
        .i_inc   (w_taken_inc),
        .o_count (stat_taken)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolver
//  Description : Scoreboard bench for branch_resolver: a driver issues ops
//                and queues the expected responses; a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

    localparam int XLEN   = 32;
    localparam int IALIGN = 4;
    localparam int CNT_W  = 16;
    localparam int K_BR   = 0;
    localparam int K_SET  = 1;
    localparam int K_ILL  = 2;

    typedef struct {
        int          kind;
        bit          taken;
        logic [31:0] target;
        bit          mis;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic             soc_clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = 4'd0;
    logic [XLEN-1:0]  req_pc = '0;
    logic [XLEN-1:0]  req_imm = '0;
    logic             cmp_con_met = 1'b0;
    logic             flush = 1'b0;
    logic             br_valid;
    logic             br_ready = 1'b0;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic             br_misaligned;
    logic             wb_valid;
    logic [XLEN-1:0]  wb_data;
    logic             op_illegal;
    logic [CNT_W-1:0] stat_resolved;
    logic [CNT_W-1:0] stat_taken;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_res = 0;
    int   exp_tk = 0;
    bit   stat_chk = 0;
    bit   br_seen = 0;
    exp_t q[$];

    branch_resolver #(.XLEN(XLEN), .IALIGN(IALIGN), .CNT_W(CNT_W)) dut (
        .soc_clk       (soc_clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_pc        (req_pc),
        .req_imm       (req_imm),
        .cmp_con_met   (cmp_con_met),
        .flush         (flush),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .br_misaligned (br_misaligned),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .op_illegal    (op_illegal),
        .stat_resolved (stat_resolved),
        .stat_taken    (stat_taken)
    );

    always #5 soc_clk = ~soc_clk;

    always @(posedge soc_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare every presented output with the queued expectation.
    always @(negedge soc_clk) begin
        if (reset) begin
            q.delete();
            exp_res  = 0;
            exp_tk   = 0;
            stat_chk = 0;
            br_seen  = 0;
        end else begin
            if (stat_chk) begin
                chk("stat_resolved", 32'(stat_resolved), 32'(exp_res));
                chk("stat_taken", 32'(stat_taken), 32'(exp_tk));
                stat_chk = 0;
            end
            if (op_illegal) begin
                if (q.size() > 0 && q[0].kind == K_ILL) begin
                    chk("illegal_cycle", 32'(cyc), 32'(q[0].cyc));
                    q.delete(0);
                end else chk("unexpected_op_illegal", 32'(1), 32'(0));
            end
            if (wb_valid) begin
                if (q.size() > 0 && q[0].kind == K_SET) begin
                    chk("wb_data", wb_data, q[0].data);
                    chk("wb_cycle", 32'(cyc), 32'(q[0].cyc));
                    q.delete(0);
                end else chk("unexpected_wb_valid", 32'(1), 32'(0));
            end
            if (br_valid) begin
                if (q.size() > 0 && q[0].kind == K_BR) begin
                    chk("br_taken", 32'(br_taken), 32'(q[0].taken));
                    chk("br_target", br_target, q[0].target);
                    chk("br_misaligned", 32'(br_misaligned), 32'(q[0].mis));
                    if (!br_seen) chk("br_first_cycle", 32'(cyc), 32'(q[0].cyc));
                    br_seen = 1;
                    if (flush) begin
                        br_seen = 0;
                    end else if (br_ready) begin
                        exp_res++;
                        if (q[0].taken) exp_tk++;
                        stat_chk = 1;
                        br_seen  = 0;
                        q.delete(0);
                    end
                end else chk("unexpected_br_valid", 32'(1), 32'(0));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge soc_clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(req_ready), 32'(1));
    endtask

    // Driver: issue one op; fl 0 = none, 1 = flush in WAIT, 2 = flush in OUT.
    task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input bit cmp, input int stall, input int fl);
        exp_t e;
        bit is_br, is_st;
        int mode, st_n;
        logic [31:0] tgt;
        is_br = (op <= 4'd5);
        is_st = (op == 4'd9) || (op == 4'd10);
        mode  = (is_br || fl == 1) ? fl : 0;
        st_n  = (mode == 2 && stall == 0) ? 1 : stall;
        wait_idle();
        req_valid = 1'b1; req_op = op; req_pc = pc; req_imm = imm;
        @(posedge soc_clk); #1;
        req_valid = 1'b0;
        if (!is_br && !is_st) begin
            e.kind = K_ILL; e.taken = 0; e.target = 0; e.mis = 0; e.data = 0; e.cyc = cyc;
            q.push_back(e);
            chk("illegal_ready", 32'(req_ready), 32'(1));
            return;
        end
        tgt      = cmp ? pc + imm : pc + 32'd4;
        e.kind   = is_br ? K_BR : K_SET;
        e.taken  = cmp;
        e.target = tgt;
        e.mis    = cmp && ((tgt % IALIGN) != 0);
        e.data   = cmp ? 32'd1 : 32'd0;
        e.cyc    = cyc + 1;
        if (mode != 1) q.push_back(e);
        cmp_con_met = cmp;
        flush       = (mode == 1);
        br_ready    = (st_n == 0 && mode == 0);
        req_valid   = 1'($urandom_range(0, 1));
        req_op      = 4'($urandom);
        @(posedge soc_clk); #1;
        cmp_con_met = 1'($urandom_range(0, 1));
        flush       = 1'b0;
        if (mode == 1) begin
            req_valid = 1'b0;
            chk("flush_wait_idle", 32'(req_ready), 32'(1));
            chk("flush_wait_quiet", 32'({br_valid, wb_valid}), 32'(0));
            return;
        end
        if (!is_br) begin
            req_valid = 1'b0;
            return;
        end
        for (int s = 0; s < st_n; s++) begin
            req_valid = 1'($urandom_range(0, 1));
            @(posedge soc_clk); #1;
        end
        if (mode == 2) begin
            flush    = 1'b1;
            br_ready = 1'($urandom_range(0, 1));
        end else begin
            br_ready = 1'b1;
        end
        @(posedge soc_clk); #1;
        flush = 1'b0; br_ready = 1'b0; req_valid = 1'b0;
        chk("br_done_idle", 32'(req_ready), 32'(1));
        chk("br_done_quiet", 32'(br_valid), 32'(0));
        if (mode == 2) begin
            if (q.size() > 0) q.delete(0);
            chk("flush_out_stat", 32'(stat_resolved), 32'(exp_res));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [3:0]  op;
        logic [31:0] pc, imm, tmp;
        int r, fl, stall;

        repeat (3) @(posedge soc_clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(1));
        chk("rst_outputs", 32'({br_valid, br_taken, br_misaligned, wb_valid, op_illegal}), 32'(0));
        chk("rst_target", br_target, 32'h0);
        chk("rst_stats", 32'({stat_resolved, stat_taken}), 32'(0));
        reset = 1'b0;

        issue(4'd0, 32'h100, 32'h20, 1, 0, 0);
        issue(4'd2, 32'h100, 32'hFFFF_FFF8, 0, 0, 0);
        issue(4'd1, 32'h200, 32'h6, 1, 0, 0);
        issue(4'd1, 32'h200, 32'h6, 0, 0, 0);
        issue(4'd10, 32'h40, 32'h0, 1, 0, 0);
        issue(4'd10, 32'h40, 32'h0, 0, 0, 0);
        issue(4'd9, 32'h44, 32'h0, 1, 0, 0);
        issue(4'd5, 32'hFFFF_FFF0, 32'h20, 1, 5, 0);
        issue(4'd3, 32'h80, 32'h10, 1, 0, 1);
        issue(4'd9, 32'h80, 32'h10, 1, 0, 1);
        issue(4'd0, 32'h80, 32'h10, 1, 2, 2);
        issue(4'd7, 32'h90, 32'h0, 1, 0, 0);

        // A request coinciding with flush must not be accepted.
        wait_idle();
        req_valid = 1'b1; req_op = 4'd0; flush = 1'b1;
        @(posedge soc_clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", 32'(req_ready), 32'(1));

        // Reset while a branch result is held in OUT.
        wait_idle();
        req_valid = 1'b1; req_op = 4'd4; req_pc = 32'h300; req_imm = 32'h40;
        @(posedge soc_clk); #1;
        req_valid = 1'b0;
        e.kind = K_BR; e.taken = 1; e.target = 32'h340; e.mis = 0; e.data = 0; e.cyc = cyc + 1;
        q.push_back(e);
        cmp_con_met = 1'b1; br_ready = 1'b0;
        @(posedge soc_clk); #1;
        @(posedge soc_clk); #1;
        reset = 1'b1;
        @(posedge soc_clk); #1;
        reset = 1'b0;
        chk("midrst_req_ready", 32'(req_ready), 32'(1));
        chk("midrst_outputs", 32'({br_valid, br_taken, br_misaligned, wb_valid, op_illegal}), 32'(0));
        chk("midrst_target", br_target, 32'h0);
        chk("midrst_stats", 32'({stat_resolved, stat_taken}), 32'(0));

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                op = (r < 3) ? 4'($urandom_range(6, 8)) : 4'($urandom_range(11, 15));
            end else begin
                r  = $urandom_range(0, 7);
                op = (r < 6) ? 4'(r) : ((r == 6) ? 4'd9 : 4'd10);
            end
            pc  = $urandom & 32'hFFFF_FFFE;
            tmp = $urandom;
            imm = tmp[31] ? tmp : {{20{tmp[11]}}, tmp[11:0]};
            r   = $urandom_range(0, 9);
            fl  = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            stall = $urandom_range(0, 3);
            issue(op, pc, imm, 1'($urandom_range(0, 1)), stall, fl);
        end

        repeat (4) @(posedge soc_clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
